// File: rtl/key_pkg.sv
// Shared types and helpers for the push-button conditioning path.
// Imported by the debounce/pulse top module.
package key_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    REPEAT,
    RELEASE_WAIT
  } key_state_t;

  // All-ones terminal count for a counter of the given width.
  function automatic logic [31:0] term_cnt(input int bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Output is cleared by the shared synchronous reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/key_debounce_pulse.sv
// Push-button conditioner: sync, debounce press/release, emit one-cycle
// press pulses and optional auto-repeat pulses while the key is held.
module key_debounce_pulse
  import key_pkg::*;
#(
  parameter int DEB_BITS  = 16,
  parameter int HOLD_BITS = 24,
  parameter int REP_BITS  = 22
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic repeat_en,
  output logic pls,
  output logic level,
  output logic held
);

  localparam logic [DEB_BITS-1:0] DEB_MAX =
    DEB_BITS'(term_cnt(DEB_BITS));
  localparam logic [HOLD_BITS-1:0] HOLD_MAX =
    HOLD_BITS'(term_cnt(HOLD_BITS));
  localparam logic [REP_BITS-1:0] REP_MAX =
    REP_BITS'(term_cnt(REP_BITS));

  logic btn_s;

  key_state_t state, state_n;

  logic [DEB_BITS-1:0]  deb_cnt, deb_n;
  logic [HOLD_BITS-1:0] hold_cnt, hold_n;
  logic [REP_BITS-1:0]  rep_cnt, rep_n;
  logic                 pls_n, level_n;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_raw),
    .q   (btn_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      deb_cnt  <= '0;
      hold_cnt <= '0;
      rep_cnt  <= '0;
      pls      <= 1'b0;
      level    <= 1'b0;
    end else begin
      state    <= state_n;
      deb_cnt  <= deb_n;
      hold_cnt <= hold_n;
      rep_cnt  <= rep_n;
      pls      <= pls_n;
      level    <= level_n;
    end
  end

  // A low btn_s is always checked first: release beats terminal count.
  always_comb begin
    state_n = state;
    deb_n   = deb_cnt;
    hold_n  = hold_cnt;
    rep_n   = rep_cnt;
    pls_n   = 1'b0;
    level_n = level;
    unique case (state)
      IDLE: begin
        if (btn_s) begin
          state_n = PRESS_WAIT;
          deb_n   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_n = IDLE;
        end else if (deb_cnt == DEB_MAX) begin
          state_n = PRESSED;
          pls_n   = 1'b1;
          level_n = 1'b1;
          hold_n  = '0;
        end else begin
          deb_n = deb_cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_n = RELEASE_WAIT;
          deb_n   = '0;
        end else if (hold_cnt == HOLD_MAX) begin
          if (repeat_en) begin
            state_n = REPEAT;
            pls_n   = 1'b1;
            rep_n   = '0;
          end
        end else begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      REPEAT: begin
        if (!btn_s) begin
          state_n = RELEASE_WAIT;
          deb_n   = '0;
        end else if (!repeat_en) begin
          state_n = PRESSED;
          hold_n  = HOLD_MAX;
        end else if (rep_cnt == REP_MAX) begin
          pls_n = 1'b1;
          rep_n = '0;
        end else begin
          rep_n = rep_cnt + 1'b1;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_n = PRESSED;
          hold_n  = '0;
        end else if (deb_cnt == DEB_MAX) begin
          state_n = IDLE;
          level_n = 1'b0;
        end else begin
          deb_n = deb_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign held = (state == REPEAT);

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Randomized and directed bench for key_debounce_pulse against an
// event-timing reference model (small DEB/HOLD/REP widths).
module tb_key_debounce_pulse;

  localparam int DB = 2;
  localparam int HB = 4;
  localparam int RB = 3;
  localparam int D  = 1 << DB;
  localparam int H  = 1 << HB;
  localparam int R  = 1 << RB;

  logic clk = 1'b0;
  logic rst;
  logic btn_raw;
  logic repeat_en;
  logic pls;
  logic level;
  logic held;

  int checks = 0;
  int errors = 0;

  int edge_n;
  int pls_edges[$];
  int held_first;

  // reference model state
  bit m_s1, m_bs, m_lvl, m_held, m_pls, m_seg;
  int m_run, m_k;

  always #5 clk = ~clk;

  key_debounce_pulse #(
    .DEB_BITS  (DB),
    .HOLD_BITS (HB),
    .REP_BITS  (RB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .repeat_en (repeat_en),
    .pls       (pls),
    .level     (level),
    .held      (held)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               tag, obs, exp, $time);
    end
  endtask

  // Model: btn_s is btn_raw delayed two edges. Level rises after D+1
  // consecutive high btn_s samples and falls after D+1 consecutive
  // lows. Within a high segment at offset k, pulses fire at k=0 (press
  // only) and at k = H + m*R when repeat is enabled.
  task automatic model_edge();
    bit b;
    m_pls = 1'b0;
    if (rst) begin
      m_s1 = 0; m_bs = 0; m_lvl = 0; m_held = 0;
      m_run = 0; m_seg = 0; m_k = 0;
    end else begin
      b = m_bs;
      if (!m_lvl) begin
        if (b) begin
          m_run++;
          if (m_run == D + 1) begin
            m_pls = 1; m_lvl = 1; m_run = 0;
            m_seg = 1; m_k = 0;
          end
        end else begin
          m_run = 0;
        end
      end else if (!b) begin
        m_seg = 0; m_held = 0; m_run++;
        if (m_run == D + 1) begin
          m_lvl = 0; m_run = 0;
        end
      end else if (!m_seg) begin
        m_seg = 1; m_k = 0; m_run = 0;
      end else begin
        m_k++;
        if (repeat_en && m_k >= H && (m_k - H) % R == 0)
          m_pls = 1;
        m_held = repeat_en && (m_k >= H);
      end
      m_bs = m_s1;
      m_s1 = btn_raw;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    edge_n++;
    #1;
    chk("pls", int'(pls), int'(m_pls));
    chk("level", int'(level), int'(m_lvl));
    chk("held", int'(held), int'(m_held));
    if (pls) pls_edges.push_back(edge_n);
    if (held && held_first < 0) held_first = edge_n;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic start_scn();
    edge_n = 0;
    held_first = -1;
    pls_edges.delete();
  endtask

  task automatic idle();
    btn_raw = 1'b0;
    steps(14);
  endtask

  initial begin
    int lat;
    int rst_edge;
    int exp_rep[6];
    exp_rep = '{7, 23, 31, 39, 47, 55};

    rst = 1'b1;
    btn_raw = 1'b0;
    repeat_en = 1'b0;
    edge_n = 0;
    held_first = -1;
    steps(3);
    chk("rst_pls", int'(pls), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_held", int'(held), 0);
    rst = 1'b0;

    // clean press, then release bounce, then stable release
    start_scn();
    btn_raw = 1'b1;
    steps(20);
    chk("press_cnt", pls_edges.size(), 1);
    if (pls_edges.size() > 0) chk("press_edge", pls_edges[0], 7);
    btn_raw = 1'b0;
    steps(2);
    btn_raw = 1'b1;
    steps(10);
    chk("relbounce_cnt", pls_edges.size(), 1);
    chk("relbounce_level", int'(level), 1);
    btn_raw = 1'b0;
    lat = 0;
    while (level && lat < 20) begin
      step();
      lat++;
    end
    chk("release_lat", lat, 7);
    idle();

    // press bounce
    start_scn();
    for (int i = 0; i < 4; i++) begin
      btn_raw = (i % 2 == 0);
      steps(2);
    end
    btn_raw = 1'b0;
    steps(12);
    chk("bounce_pls", pls_edges.size(), 0);
    chk("bounce_level", int'(level), 0);

    // auto-repeat
    repeat_en = 1'b1;
    start_scn();
    btn_raw = 1'b1;
    steps(60);
    chk("rep_cnt", pls_edges.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < pls_edges.size()) chk("rep_edge", pls_edges[i], exp_rep[i]);
    chk("held_first", held_first, 23);
    idle();

    // repeat disabled
    repeat_en = 1'b0;
    steps(2);
    start_scn();
    btn_raw = 1'b1;
    steps(60);
    chk("norep_cnt", pls_edges.size(), 1);
    chk("norep_held", held_first, -1);
    idle();

    // reset while in REPEAT
    repeat_en = 1'b1;
    steps(2);
    start_scn();
    btn_raw = 1'b1;
    steps(30);
    chk("pre_rst_held", int'(held), 1);
    rst = 1'b1;
    step();
    rst_edge = edge_n;
    rst = 1'b0;
    chk("mid_rst_pls", int'(pls), 0);
    chk("mid_rst_level", int'(level), 0);
    chk("mid_rst_held", int'(held), 0);
    chk("mid_rst_state", int'(dut.state), 0);
    pls_edges.delete();
    steps(10);
    chk("rst_repress_cnt", pls_edges.size(), 1);
    if (pls_edges.size() > 0)
      chk("rst_repress_edge", pls_edges[0] - rst_edge, 7);
    idle();

    // randomized episodes
    for (int ep = 0; ep < 15; ep++) begin
      repeat_en = 1'($urandom_range(0, 1));
      steps(2);
      for (int s = 0; s < int'($urandom_range(3, 8)); s++) begin
        btn_raw = (s % 2 == 0);
        steps(int'($urandom_range(1, 30)));
      end
      idle();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
